// File: rtl/cpu_types_pkg.sv
// Shared types for the direct-mapped write-back data cache.
package cpu_types_pkg;

  localparam int NSETS = 16;
  localparam int IDX_W = $clog2(NSETS);
  localparam int TAG_W = 32 - IDX_W - 3;

  typedef enum logic [3:0] {
    IDLE, WB0, WB1, LD0, LD1, FLUSH, FWB0, FWB1, DONE
  } dcache_state_t;

  // Byte address split into its cache fields.
  typedef struct packed {
    logic [TAG_W-1:0] tag;
    logic [IDX_W-1:0] idx;
    logic             blkoff;
    logic [1:0]       bytoff;
  } dcachef_t;

  typedef struct packed {
    logic             valid;
    logic             dirty;
    logic [TAG_W-1:0] tag;
    logic [1:0][31:0] word;
  } dframe_t;

  // Word-aligned memory address of one word of a block.
  function automatic logic [31:0] blk_addr(logic [TAG_W-1:0] tag,
                                           logic [IDX_W-1:0] idx,
                                           logic off);
    return {tag, idx, off, 2'b00};
  endfunction

endpackage

// File: rtl/dcache_direct_wb_frame_array.sv
// Frame storage: NSETS frames, one combinational read port, one write port.
// Clear drops valid/dirty on every frame; tags and data are left as they are.
module dcache_frame_array
  import cpu_types_pkg::*;
(
  input  logic             clk,
  input  logic             clr,
  input  logic [IDX_W-1:0] rd_idx,
  output dframe_t          rd_frame,
  input  logic             we,
  input  logic [IDX_W-1:0] wr_idx,
  input  dframe_t          wr_frame
);

  dframe_t frames [NSETS];

  assign rd_frame = frames[rd_idx];

  // Synchronous clear has priority over the write port.
  always_ff @(posedge clk) begin
    if (clr) begin
      for (int i = 0; i < NSETS; i++) begin
        frames[i].valid <= 1'b0;
        frames[i].dirty <= 1'b0;
      end
    end else if (we) begin
      frames[wr_idx] <= wr_frame;
    end
  end

endmodule

// File: rtl/dcache_direct_wb.sv
// Direct-mapped, write-back, write-allocate data cache with 2-word blocks.
// Hits are answered in the same cycle; misses write back a dirty victim and
// refill from memory; halt flushes every dirty frame and then parks in DONE.
//
// Memory handshake: dREN/dWEN with daddr/dstore are a request held stable
// while dwait = 1; the request is accepted (and dload sampled for reads) on
// the rising edge where dwait = 0. dREN and dWEN are never high together.
module dcache_direct_wb
  import cpu_types_pkg::*;
(
  input  logic          CLK,
  input  logic          nRST,
  input  logic          dmemREN,
  input  logic          dmemWEN,
  input  logic [31:0]   dmemaddr,
  input  logic [31:0]   dmemstore,
  input  logic          halt,
  output logic          dhit,
  output logic [31:0]   dmemload,
  output logic          flushed,
  output logic          dREN,
  output logic          dWEN,
  output logic [31:0]   daddr,
  output logic [31:0]   dstore,
  input  logic [31:0]   dload,
  input  logic          dwait,
  output dcache_state_t state
);

  dcachef_t         req;
  logic [TAG_W-1:0] miss_tag;
  logic [IDX_W-1:0] miss_idx;
  logic [IDX_W-1:0] fcnt;
  logic [31:0]      ld_buf;
  logic [IDX_W-1:0] rd_idx;
  dframe_t          rd_frame;
  logic             we;
  logic [IDX_W-1:0] wr_idx;
  dframe_t          wr_frame;
  logic             req_any;
  logic             hit;
  logic             last_idx;
  logic             unused_bits;

  assign req         = dcachef_t'(dmemaddr);
  assign unused_bits = ^req.bytoff;
  assign req_any     = dmemREN | dmemWEN;
  assign hit         = rd_frame.valid && (rd_frame.tag == req.tag);
  assign last_idx    = (fcnt == IDX_W'(NSETS - 1));

  dcache_frame_array u_frames (
    .clk      (CLK),
    .clr      (!nRST),
    .rd_idx   (rd_idx),
    .rd_frame (rd_frame),
    .we       (we),
    .wr_idx   (wr_idx),
    .wr_frame (wr_frame)
  );

  // Read port follows the request in IDLE, the latched miss while refilling,
  // and the flush counter while flushing.
  always_comb begin
    rd_idx = req.idx;
    case (state)
      WB0, WB1, LD0, LD1:  rd_idx = miss_idx;
      FLUSH, FWB0, FWB1:   rd_idx = fcnt;
      default:             rd_idx = req.idx;
    endcase
  end

  // Zero-latency hit; halt in IDLE takes priority over any request.
  assign dhit     = (state == IDLE) && !halt && req_any && hit;
  assign dmemload = (dhit && dmemREN && !dmemWEN) ? rd_frame.word[req.blkoff] : 32'h0;

  // Frame updates: store hit merges one word and marks dirty; the second
  // refill accept installs the whole block clean.
  always_comb begin
    we       = 1'b0;
    wr_idx   = miss_idx;
    wr_frame = rd_frame;
    if (dhit && dmemWEN) begin
      we                         = 1'b1;
      wr_idx                     = req.idx;
      wr_frame.dirty             = 1'b1;
      wr_frame.word[req.blkoff]  = dmemstore;
    end else if (state == LD1 && !dwait) begin
      we             = 1'b1;
      wr_frame.valid = 1'b1;
      wr_frame.dirty = 1'b0;
      wr_frame.tag   = miss_tag;
      wr_frame.word  = {dload, ld_buf};
    end
  end

  // Memory request outputs are a pure function of state and the frame read,
  // so they stay stable for as long as dwait holds the state.
  always_comb begin
    dREN   = 1'b0;
    dWEN   = 1'b0;
    daddr  = 32'h0;
    dstore = 32'h0;
    case (state)
      WB0, FWB0: begin
        dWEN   = 1'b1;
        daddr  = blk_addr(rd_frame.tag, rd_idx, 1'b0);
        dstore = rd_frame.word[0];
      end
      WB1, FWB1: begin
        dWEN   = 1'b1;
        daddr  = blk_addr(rd_frame.tag, rd_idx, 1'b1);
        dstore = rd_frame.word[1];
      end
      LD0: begin
        dREN  = 1'b1;
        daddr = blk_addr(miss_tag, miss_idx, 1'b0);
      end
      LD1: begin
        dREN  = 1'b1;
        daddr = blk_addr(miss_tag, miss_idx, 1'b1);
      end
      default: ;
    endcase
  end

  // Controller FSM: miss handling, flush walk and the terminal DONE state.
  always_ff @(posedge CLK) begin
    if (!nRST) begin
      state    <= IDLE;
      fcnt     <= '0;
      miss_tag <= '0;
      miss_idx <= '0;
      ld_buf   <= 32'h0;
      flushed  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (halt) begin
            state <= FLUSH;
            fcnt  <= '0;
          end else if (req_any && !hit) begin
            miss_tag <= req.tag;
            miss_idx <= req.idx;
            state    <= (rd_frame.valid && rd_frame.dirty) ? WB0 : LD0;
          end
        end
        WB0:  if (!dwait) state <= WB1;
        WB1:  if (!dwait) state <= LD0;
        LD0: begin
          if (!dwait) begin
            ld_buf <= dload;
            state  <= LD1;
          end
        end
        LD1:  if (!dwait) state <= IDLE;
        FLUSH: begin
          if (rd_frame.valid && rd_frame.dirty) begin
            state <= FWB0;
          end else if (last_idx) begin
            state   <= DONE;
            flushed <= 1'b1;
          end else begin
            fcnt <= fcnt + 1'b1;
          end
        end
        FWB0: if (!dwait) state <= FWB1;
        FWB1: begin
          if (!dwait) begin
            if (last_idx) begin
              state   <= DONE;
              flushed <= 1'b1;
            end else begin
              fcnt  <= fcnt + 1'b1;
              state <= FLUSH;
            end
          end
        end
        DONE:    flushed <= 1'b1;
        default: state   <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dcache_direct_wb.sv
// Bench for dcache_direct_wb: random-latency memory responder, architectural
// memory plus tag-level cache reference model, queue-based scoreboards.
module tb_dcache_direct_wb;
  import cpu_types_pkg::*;

  // ---------------- clock / reset / DUT ----------------
  logic          CLK = 1'b0;
  logic          nRST = 1'b0;
  logic          dmemREN = 1'b0, dmemWEN = 1'b0, halt = 1'b0, dwait = 1'b1;
  logic [31:0]   dmemaddr = 32'h0, dmemstore = 32'h0, dload = 32'h0;
  logic          dhit, flushed, dREN, dWEN;
  logic [31:0]   dmemload, daddr, dstore;
  dcache_state_t state;

  always #5 CLK = ~CLK;

  dcache_direct_wb dut (
    .CLK(CLK), .nRST(nRST), .dmemREN(dmemREN), .dmemWEN(dmemWEN),
    .dmemaddr(dmemaddr), .dmemstore(dmemstore), .halt(halt),
    .dhit(dhit), .dmemload(dmemload), .flushed(flushed),
    .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
    .dload(dload), .dwait(dwait), .state(state)
  );

  // ---------------- scoreboard state ----------------
  int checks = 0;
  int errors = 0;
  logic [31:0] exp_q[$];      // expected load data, in request order
  logic [64:0] exp_txn[$];    // expected memory accepts {we, addr, data}

  function automatic void check(string name, logic [95:0] act, logic [95:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endfunction

  function automatic void fail_now(string name, logic [95:0] act);
    checks++;
    errors++;
    $display("FAIL %s: got %0h with nothing expected (t=%0t)", name, act, $time);
  endfunction

  // ---------------- reference model ----------------
  // Architectural memory view (what a load must return) and the backing
  // store the responder serves; the cache model tracks only tags/valid/dirty.
  logic [31:0] arch [logic [31:0]];
  logic [31:0] mem  [logic [31:0]];
  bit          m_valid [16];
  bit          m_dirty [16];
  logic [24:0] m_tag   [16];

  function automatic logic [31:0] init_val(logic [31:0] a);
    return a ^ 32'h1357_9BDF;
  endfunction

  function automatic logic [31:0] arch_rd(logic [31:0] a);
    return arch.exists(a) ? arch[a] : init_val(a);
  endfunction

  function automatic logic [31:0] mem_rd(logic [31:0] a);
    return mem.exists(a) ? mem[a] : init_val(a);
  endfunction

  // Applies one request to the model, queues its expected traffic and load
  // data, and returns whether it should hit.
  function automatic bit model_req(bit we, logic [31:0] addr, logic [31:0] data);
    logic [3:0]  idx;
    logic [24:0] tag;
    logic [31:0] wa, a;
    bit          hit;
    idx = addr[6:3];
    tag = addr[31:7];
    wa  = {addr[31:2], 2'b00};
    hit = m_valid[idx] && (m_tag[idx] == tag);
    if (!hit) begin
      if (m_valid[idx] && m_dirty[idx])
        for (int o = 0; o < 2; o++) begin
          a = {m_tag[idx], idx, 1'(o), 2'b00};
          exp_txn.push_back({1'b1, a, arch_rd(a)});
        end
      for (int o = 0; o < 2; o++)
        exp_txn.push_back({1'b0, tag, idx, 1'(o), 2'b00, 32'h0});
      m_valid[idx] = 1'b1;
      m_dirty[idx] = 1'b0;
      m_tag[idx]   = tag;
    end
    if (we) begin
      m_dirty[idx] = 1'b1;
      arch[wa]     = data;
    end else begin
      exp_q.push_back(arch_rd(wa));
    end
    return hit;
  endfunction

  function automatic void model_flush();
    logic [31:0] a;
    for (int i = 0; i < 16; i++)
      if (m_valid[i] && m_dirty[i]) begin
        for (int o = 0; o < 2; o++) begin
          a = {m_tag[i], 4'(i), 1'(o), 2'b00};
          exp_txn.push_back({1'b1, a, arch_rd(a)});
        end
        m_dirty[i] = 1'b0;
      end
  endfunction

  // Cache contents are lost on reset: the architectural view becomes memory.
  function automatic void model_reset();
    for (int i = 0; i < 16; i++) begin
      m_valid[i] = 1'b0;
      m_dirty[i] = 1'b0;
    end
    exp_q.delete();
    exp_txn.delete();
    arch = mem;
  endfunction

  // ---------------- memory responder / monitor ----------------
  int          accept_budget = -1;  // -1: unlimited accepts
  int          stall_left = 0;      // forced dwait cycles for the next request
  bit          prev_stalled = 1'b0;
  logic [65:0] prev_req, cur_req;
  logic [64:0] act_txn, exp_t;
  bit          stall;

  always @(negedge CLK) begin
    if (dREN || dWEN) begin
      cur_req = {dREN, dWEN, daddr, dstore};
      check("no_dual_req", {95'h0, dREN & dWEN}, 96'h0);
      if (prev_stalled) check("hold_stable", cur_req, prev_req);
      if (accept_budget == 0) stall = 1'b1;
      else if (stall_left > 0) begin
        stall = 1'b1;
        stall_left--;
      end else stall = ($urandom_range(0, 3) == 0);
      if (stall) begin
        dwait        = 1'b1;
        prev_stalled = 1'b1;
        prev_req     = cur_req;
      end else begin
        dwait        = 1'b0;
        prev_stalled = 1'b0;
        if (accept_budget > 0) accept_budget--;
        act_txn = {dWEN, daddr, dWEN ? dstore : 32'h0};
        if (exp_txn.size() == 0) fail_now("unexpected_mem_req", act_txn);
        else begin
          exp_t = exp_txn.pop_front();
          check("mem_txn", act_txn, exp_t);
        end
        if (dWEN) mem[daddr] = dstore;
        else      dload = mem_rd(daddr);
      end
    end else begin
      dwait        = 1'b1;
      prev_stalled = 1'b0;
    end
  end

  // Load-response monitor: every load hit pops one expected value.
  logic [31:0] exp_ld;
  always @(negedge CLK) begin
    if (nRST && dhit && dmemREN && !dmemWEN) begin
      if (exp_q.size() == 0) fail_now("unexpected_load_hit", dmemload);
      else begin
        exp_ld = exp_q.pop_front();
        check("load_data", dmemload, exp_ld);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic do_req(bit we, bit ren, logic [31:0] addr, logic [31:0] data);
    bit exp_hit;
    int n;
    exp_hit = model_req(we, addr, data);
    @(posedge CLK); #1;
    dmemREN = ren; dmemWEN = we; dmemaddr = addr; dmemstore = data;
    n = 0;
    while (1) begin
      @(negedge CLK);
      if (dhit) break;
      n++;
      if (n > 300) begin
        fail_now("dhit_timeout", addr);
        break;
      end
    end
    if (exp_hit) check("hit_latency", n, 0);
    else         check("miss_not_instant", {95'h0, n > 0}, 96'h1);
    @(posedge CLK); #1;
    dmemREN = 1'b0; dmemWEN = 1'b0;
  endtask

  task automatic do_reset();
    @(posedge CLK); #1;
    nRST = 1'b0; dmemREN = 1'b0; dmemWEN = 1'b0; halt = 1'b0;
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    check("rst_state",   state,    IDLE);
    check("rst_dhit",    dhit,     0);
    check("rst_dren",    dREN,     0);
    check("rst_dwen",    dWEN,     0);
    check("rst_flushed", flushed,  0);
    check("rst_daddr",   daddr,    0);
    check("rst_dstore",  dstore,   0);
    check("rst_dmemload", dmemload, 0);
    @(posedge CLK); #1;
    nRST = 1'b1;
    model_reset();
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int n;
    logic [31:0] a;
    do_reset();

    // Cold load with known refill data, store hit, reload.
    mem[32'h40] = 32'hAAAA_0001; mem[32'h44] = 32'hAAAA_0002;
    arch[32'h40] = 32'hAAAA_0001; arch[32'h44] = 32'hAAAA_0002;
    do_req(1'b0, 1'b1, 32'h0000_0040, 32'h0);
    do_req(1'b1, 1'b0, 32'h0000_0044, 32'hDEAD_BEEF);
    do_req(1'b0, 1'b1, 32'h0000_0044, 32'h0);
    // Conflict at index 8 forces write-back of the dirty block.
    do_req(1'b0, 1'b1, 32'h0000_0840, 32'h0);

    // Five forced stall cycles on the first refill request.
    stall_left = 5;
    do_req(1'b0, 1'b1, 32'h0000_1000, 32'h0);
    check("stall_consumed", stall_left, 0);

    // Both enables high behaves as a store.
    do_req(1'b1, 1'b1, 32'h0000_0848, 32'h1234_5678);
    do_req(1'b0, 1'b1, 32'h0000_0848, 32'h0);

    // Random traffic over four tags to mix hits, clean and dirty misses.
    for (int i = 0; i < 80; i++) begin
      a = {23'h0, 2'($urandom_range(0, 3)), 4'($urandom_range(0, 15)),
           1'($urandom_range(0, 1)), 2'($urandom_range(0, 3))};
      if ($urandom_range(0, 1) == 1) do_req(1'b1, 1'b0, a, $urandom);
      else                           do_req(1'b0, 1'b1, a, 32'h0);
    end

    // Reset while the write-back waits in WB1.
    do_req(1'b1, 1'b0, 32'h0000_0044, 32'hCAFE_F00D);
    accept_budget = 1;
    void'(model_req(1'b0, 32'h0000_0840, 32'h0));
    @(posedge CLK); #1;
    dmemREN = 1'b1; dmemaddr = 32'h0000_0840;
    n = 0;
    while (state != WB1 && n < 200) begin
      @(negedge CLK);
      n++;
    end
    check("reached_wb1", state, WB1);
    @(posedge CLK); #1;
    nRST = 1'b0; dmemREN = 1'b0;
    @(posedge CLK); #1;
    nRST = 1'b1;
    @(negedge CLK);
    check("abort_dren",  dREN,  0);
    check("abort_dwen",  dWEN,  0);
    check("abort_state", state, IDLE);
    model_reset();
    accept_budget = -1;
    do_req(1'b0, 1'b1, 32'h0000_0044, 32'h0);

    // Flush with dirty frames only at index 2 and 15.
    do_reset();
    do_req(1'b1, 1'b0, 32'h0000_0010, 32'h0202_0202);
    do_req(1'b1, 1'b0, 32'h0000_007C, 32'h0F0F_0F0F);
    do_req(1'b0, 1'b1, 32'h0000_0028, 32'h0);
    model_flush();
    check("flush_txn_count", exp_txn.size(), 4);
    @(posedge CLK); #1;
    halt = 1'b1;
    n = 0;
    while (!flushed && n < 300) begin
      @(negedge CLK);
      n++;
    end
    check("flushed_set", flushed, 1);
    check("flush_all_written", exp_txn.size(), 0);
    @(posedge CLK); #1;
    dmemREN = 1'b1; dmemaddr = 32'h0000_0010;
    repeat (5) begin
      @(negedge CLK);
      check("done_flushed", flushed, 1);
      check("done_no_hit",  dhit,    0);
      check("done_state",   state,   DONE);
      check("done_no_mem",  {94'h0, dREN, dWEN}, 96'h0);
    end
    dmemREN = 1'b0;

    check("exp_txn_empty", exp_txn.size(), 0);
    check("exp_load_empty", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Global time bound.
  initial begin
    #500000;
    errors++;
    $display("FAIL watchdog: simulation did not complete in time");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $fatal(1, "watchdog expired");
  end

endmodule
